// File: rtl/csr_read_unit.sv
// csr_read_unit: CSR read-modify-write unit owning mscratch, tohost and the 64-bit cycle/instret counters
module csr_read_unit #(
  parameter logic [11:0] TOHOST_ADDR   = 12'h51E,
  parameter logic [11:0] MSCRATCH_ADDR = 12'h340,
  parameter logic [63:0] CYCLE_RESET   = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_src,
  input  logic        csr_src_zero,
  input  logic        instr_retire,
  output logic [31:0] csr_rdata,
  output logic        csr_rdata_valid,
  output logic        csr_illegal,
  output logic [31:0] tohost
);
  logic [63:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0] mscratch_q, mscratch_d, tohost_q, tohost_d, rdata_q, rdata_d;
  logic        valid_q, illegal_q, illegal_d;
  logic        hit_ms, hit_th, hit_ro, wen, bad, do_wr;
  logic [31:0] old_val, new_val;
  // decode the address, form the old value and the read-modify-write result
  always_comb begin
    hit_ms     = csr_addr == MSCRATCH_ADDR;
    hit_th     = csr_addr == TOHOST_ADDR;
    hit_ro     = csr_addr == 12'hC00 || csr_addr == 12'hC80 || csr_addr == 12'hC02 || csr_addr == 12'hC82;
    old_val    = hit_ms ? mscratch_q :
                 hit_th ? tohost_q :
                 csr_addr == 12'hC00 ? cycle_q[31:0] :
                 csr_addr == 12'hC80 ? cycle_q[63:32] :
                 csr_addr == 12'hC02 ? instret_q[31:0] :
                 csr_addr == 12'hC82 ? instret_q[63:32] : 32'd0;
    new_val    = csr_op == 2'b01 ? csr_src :
                 csr_op == 2'b10 ? (old_val | csr_src) : (old_val & ~csr_src);
    wen        = csr_valid && (csr_op == 2'b01 || !csr_src_zero);
    bad        = !(hit_ms || hit_th || hit_ro) || csr_op == 2'b00 || (wen && hit_ro);
    illegal_d  = csr_valid && bad;
    do_wr      = wen && !bad;
    mscratch_d = (do_wr && hit_ms) ? new_val : mscratch_q;
    tohost_d   = (do_wr && hit_th) ? new_val : tohost_q;
    rdata_d    = csr_valid ? (bad ? 32'd0 : old_val) : rdata_q;
    cycle_d    = cycle_q + 64'd1;
    instret_d  = instret_q + {63'd0, instr_retire};
  end
  // architectural state and registered response, reset dominates any request
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q    <= CYCLE_RESET;
      instret_q  <= 64'd0;
      mscratch_q <= 32'd0;
      tohost_q   <= 32'd0;
      rdata_q    <= 32'd0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      mscratch_q <= mscratch_d;
      tohost_q   <= tohost_d;
      rdata_q    <= rdata_d;
      valid_q    <= csr_valid;
      illegal_q  <= illegal_d;
    end
  end
  assign csr_rdata       = rdata_q;
  assign csr_rdata_valid = valid_q;
  assign csr_illegal     = illegal_q;
  assign tohost          = tohost_q;
endmodule

// File: doc/csr_read_unit.md
Name: csr_read_unit

Overview:
- CSR access unit for the three-stage RISC-V pipeline.
- Executes CSRRW/CSRRS/CSRRC (and immediate forms, with the zimm already muxed onto the source operand), returning the old CSR value for rd writeback.
- Owns the architectural CSR storage: mscratch, tohost and the 64-bit cycle/instret counters.
- Accepts one request per cycle from the execute stage and delivers read data registered, one cycle later, to the writeback stage.

Parameters:
- TOHOST_ADDR, 12'h51E, address of the tohost CSR (read/write).
- MSCRATCH_ADDR, 12'h340, address of the mscratch CSR (read/write).
- CYCLE_RESET, 64'd0, reset value of the cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- csr_valid  input  1  request valid this cycle; already qualified by stall/flush.
- csr_op  input  2  2'b01 RW, 2'b10 RS, 2'b11 RC, 2'b00 reserved (treated as illegal).
- csr_addr  input  12  CSR address.
- csr_src  input  32  rs1 value or zero-extended zimm.
- csr_src_zero  input  1  rs1 index / zimm field is zero (suppresses RS/RC write).
- instr_retire  input  1  one instruction retired this cycle.
- csr_rdata  output  32  old CSR value, registered.
- csr_rdata_valid  output  1  csr_rdata holds a completed access.
- csr_illegal  output  1  registered; access was illegal.
- tohost  output  32  current tohost contents.

Behaviour:
- Reset, when rst is high at a clock edge:
  - csr_rdata=0, csr_rdata_valid=0, csr_illegal=0.
  - tohost=0, mscratch=0, cycle=CYCLE_RESET, instret=0.
  - Reset overrides any concurrent request or retire, including mid-access; a request presented in the reset cycle is dropped.
- Address map (unlisted addresses are unimplemented):
  - MSCRATCH_ADDR and TOHOST_ADDR: read/write.
  - 0xC00 / 0xC80: cycle[31:0] / cycle[63:32], read-only.
  - 0xC02 / 0xC82: instret[31:0] / instret[63:32], read-only.
- Write enable: csr_valid && (op==RW || !csr_src_zero).
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Illegal access, flagged on any of:
  - unimplemented address;
  - op==00;
  - write enable asserted to a read-only address.
  - Read-only CSRs accessed via RS/RC with csr_src_zero=1 are legal reads.
- Timing, request in cycle N:
  - The old value is sampled combinationally in cycle N.
  - The write commits at the edge ending cycle N.
  - csr_rdata, csr_rdata_valid=1 and csr_illegal are presented in cycle N+1.
  - If no request occurs in N, csr_rdata_valid=0 in N+1 and csr_rdata holds its prior value.
- Illegal access response:
  - No state change.
  - csr_rdata=0, csr_rdata_valid=1, csr_illegal=1.
- Back-to-back accesses to the same CSR: the cycle N+1 access reads the value written in N. Storage is updated at the edge, so no bypass is needed; this must still be verified.
- Counters:
  - cycle increments by 1 at every non-reset edge.
  - instret increments by 1 at each edge where instr_retire=1.
  - Both are 64-bit and wrap to 0 from all-ones, with the carry propagating from the low word into the high word.
  - A read returns the pre-increment value for that cycle.
- tohost is driven directly from storage and updates the cycle after the write edge.

Test Plan:
- Reset then idle 5 cycles -> tohost=0; csr_rdata_valid=0; CSRRS x0 of 0xC00 in the 6th post-reset cycle (cycle N=5) -> csr_rdata=5 next cycle.
- CSRRW 0x51E src=0x00000001 -> csr_rdata=0, valid=1, illegal=0; tohost=1 from the following cycle; immediate CSRRS 0x51E src_zero=1 -> csr_rdata=1.
- mscratch preset 0xF0F0F0F0: CSRRS src=0x0000000F -> rdata 0xF0F0F0F0, new 0xF0F0F0FF; then CSRRC src=0xF0000000 -> rdata 0xF0F0F0FF, new 0x00F0F0FF.
- CSRRW to 0xC02 src=7 -> csr_illegal=1, rdata=0, instret unchanged; access to 0x7FF -> illegal; op=00 -> illegal.
- Force instret low word to 0xFFFFFFFF, pulse instr_retire once -> read 0xC02 returns 0, 0xC82 returns 1.
- Assert rst during a CSRRW to 0x340 -> mscratch=0 and csr_rdata_valid=0 next cycle; the write is lost.
